reg_mux_arb: RTL and testbench

REG_MUX_ARB -- requirements
Module: reg_mux_arb

---
 rtl/reg_mux_arb.sv | 105 ++++++++++
 tb/tb_reg_mux_arb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/reg_mux_arb.sv
// N-source to one registered output mux with either external select or
// round-robin arbitration, behind a single-entry valid/ready output stage.

module reg_mux_arb_lane #(
  parameter int WIDTH = 32
) (
  input  logic             gnt,
  input  logic             vld,
  input  logic             ok,
  input  logic [WIDTH-1:0] din,
  output logic             rdy,
  output logic [WIDTH-1:0] dout
);
  // Ready-gated data so the top can build the mux as a plain OR tree.
  assign rdy  = gnt & vld & ok;
  assign dout = din & {WIDTH{rdy}};
endmodule

module reg_mux_arb #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int MODE  = 0,
  localparam int SW   = ($clog2(NSRC) < 1) ? 1 : $clog2(NSRC)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [NSRC*WIDTH-1:0] In_data,
  input  logic [NSRC-1:0]       In_valid,
  output logic [NSRC-1:0]       In_ready,
  input  logic [SW-1:0]         Sel,
  input  logic                  Hold,
  output logic [WIDTH-1:0]      Out,
  output logic                  Out_valid,
  input  logic                  Out_ready,
  output logic [SW-1:0]         Out_src
);

  logic [SW-1:0]                rr_ptr;
  logic [SW-1:0]                gidx;
  logic                         gvld;
  logic                         ok;
  logic                         xfer;
  logic [NSRC-1:0]              gnt_oh;
  logic [NSRC-1:0][WIDTH-1:0]   lane_d;
  logic [WIDTH-1:0]             mux_d;

  assign ok   = (!Out_valid || Out_ready) && !Hold;
  assign xfer = |In_ready;

  // Grant index: external select, or first valid source at/after rr_ptr.
  always_comb begin
    gidx = '0;
    gvld = 1'b0;
    if (MODE == 0) begin
      gidx = Sel;
      gvld = 32'(Sel) < NSRC;
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        int idx;
        idx = (int'(rr_ptr) + k) % NSRC;
        if (!gvld && In_valid[idx]) begin
          gvld = 1'b1;
          gidx = SW'(idx);
        end
      end
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_lane
    assign gnt_oh[i] = gvld && (gidx == SW'(i));
    reg_mux_arb_lane #(.WIDTH(WIDTH)) u_lane (
      .gnt  (gnt_oh[i]),
      .vld  (In_valid[i]),
      .ok   (ok),
      .din  (In_data[i*WIDTH +: WIDTH]),
      .rdy  (In_ready[i]),
      .dout (lane_d[i])
    );
  end

  always_comb begin
    mux_d = '0;
    for (int i = 0; i < NSRC; i++) mux_d = mux_d | lane_d[i];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Out       <= '0;
      Out_src   <= '0;
      Out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        Out       <= mux_d;
        Out_src   <= gidx;
        Out_valid <= 1'b1;
      end else if (Out_ready) begin
        Out_valid <= 1'b0;
      end
      if (MODE == 1 && xfer)
        rr_ptr <= (gidx == SW'(NSRC-1)) ? '0 : SW'(gidx + 1'b1);
    end
  end

endmodule

// File: tb/tb_reg_mux_arb.sv
// Directed bench: select-mode (4 and 3 sources) and round-robin instances
// driven with hand-computed vectors.

module tb_reg_mux_arb;

  logic Clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  // u0: select mode, 4 sources
  logic [127:0] d0 = '0;
  logic [3:0]   v0 = '0, r0;
  logic [1:0]   sel0 = '0, src0;
  logic         hold0 = 1'b0, ordy0 = 1'b0, vld0;
  logic [31:0]  out0;

  // u1: round-robin, 4 sources
  logic [127:0] d1 = '0;
  logic [3:0]   v1 = '0, r1;
  logic [1:0]   sel1 = '0, src1;
  logic         hold1 = 1'b0, ordy1 = 1'b0, vld1;
  logic [31:0]  out1;

  // u2: select mode, 3 sources
  logic [95:0]  d2 = '0;
  logic [2:0]   v2 = '0, r2;
  logic [1:0]   sel2 = '0, src2;
  logic         hold2 = 1'b0, ordy2 = 1'b0, vld2;
  logic [31:0]  out2;

  reg_mux_arb #(.WIDTH(32), .NSRC(4), .MODE(0)) u0 (
    .Clk(Clk), .Reset_n(rst_n), .In_data(d0), .In_valid(v0), .In_ready(r0),
    .Sel(sel0), .Hold(hold0), .Out(out0), .Out_valid(vld0),
    .Out_ready(ordy0), .Out_src(src0));

  reg_mux_arb #(.WIDTH(32), .NSRC(4), .MODE(1)) u1 (
    .Clk(Clk), .Reset_n(rst_n), .In_data(d1), .In_valid(v1), .In_ready(r1),
    .Sel(sel1), .Hold(hold1), .Out(out1), .Out_valid(vld1),
    .Out_ready(ordy1), .Out_src(src1));

  reg_mux_arb #(.WIDTH(32), .NSRC(3), .MODE(0)) u2 (
    .Clk(Clk), .Reset_n(rst_n), .In_data(d2), .In_valid(v2), .In_ready(r2),
    .Sel(sel2), .Hold(hold2), .Out(out2), .Out_valid(vld2),
    .Out_ready(ordy2), .Out_src(src2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state, before any clock edge
    #3;
    chk("rst_out0", out0, 0); chk("rst_vld0", vld0, 0); chk("rst_src0", src0, 0);
    chk("rst_out1", out1, 0); chk("rst_vld1", vld1, 0);
    chk("rst_vld2", vld2, 0);

    // Select mode; first transfer on first edge after release
    @(negedge Clk);
    rst_n = 1'b1;
    sel0 = 2'd2; v0 = 4'b0100; ordy0 = 1'b1;
    d0 = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
    sel2 = 2'd3; v2 = 3'b111; ordy2 = 1'b1;
    d2 = {32'h000000C2, 32'h000000C1, 32'h000000C0};
    #1;
    chk("sel_rdy", r0, 4'b0100);
    chk("oob_rdy", r2, 0);
    @(posedge Clk); #1;
    chk("sel_out", out0, 32'hDEADBEEF);
    chk("sel_src", src0, 2);
    chk("sel_vld", vld0, 1);
    chk("oob_vld", vld2, 0);

    @(negedge Clk);
    v0 = 4'b0000; sel2 = 2'd2;
    #1;
    chk("idle_rdy", r0, 0);
    chk("sel3_rdy", r2, 3'b100);
    @(posedge Clk); #1;
    chk("drain_vld", vld0, 0);
    chk("drain_out", out0, 32'hDEADBEEF);
    chk("drain_src", src0, 2);
    chk("sel3_out", out2, 32'hC2);
    chk("sel3_src", src2, 2);

    // Round-robin with all sources valid
    @(negedge Clk);
    d1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    v1 = 4'b1111; ordy1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk); #1;
      chk("rr_src", src1, 64'(k % 4));
      chk("rr_vld", vld1, 1);
      chk("rr_out", out1, 64'(32'hA0 + k % 4));
    end

    // Backpressure: output held, no ready, for three cycles
    ordy1 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clk); #1;
      chk("bp_rdy", r1, 0);
      @(posedge Clk); #1;
      chk("bp_src", src1, 1);
      chk("bp_out", out1, 32'hA1);
      chk("bp_vld", vld1, 1);
    end
    @(negedge Clk);
    ordy1 = 1'b1;
    #1 chk("bp_rel_rdy", r1, 4'b0100);
    @(posedge Clk); #1;
    chk("bp_rel_src", src1, 2);
    chk("bp_rel_out", out1, 32'hA2);

    // Hold blocks grant but not consumption
    @(negedge Clk);
    hold1 = 1'b1; v1 = 4'b0010;
    #1 chk("hold_rdy", r1, 0);
    @(posedge Clk); #1;
    chk("hold_vld", vld1, 0);
    chk("hold_src", src1, 2);
    @(negedge Clk);
    hold1 = 1'b0;
    #1 chk("unhold_rdy", r1, 4'b0010);
    @(posedge Clk); #1;
    chk("unhold_src", src1, 1);
    chk("unhold_vld", vld1, 1);
    chk("unhold_out", out1, 32'hA1);

    // rr_ptr frozen across two held cycles (pointer is 2 here)
    @(negedge Clk);
    hold1 = 1'b1; v1 = 4'b1111;
    #1 chk("frz_rdy_a", r1, 0);
    @(posedge Clk);
    @(negedge Clk); #1;
    chk("frz_rdy_b", r1, 0);
    @(posedge Clk);
    @(negedge Clk);
    hold1 = 1'b0;
    #1 chk("frz_ptr_rdy", r1, 4'b0100);
    @(posedge Clk); #1;
    chk("frz_src", src1, 2);

    // Load 12345678 from source 1 (pointer becomes 2), then async reset
    @(negedge Clk);
    d1 = {32'hA3, 32'hA2, 32'h12345678, 32'hA0};
    v1 = 4'b0010;
    @(posedge Clk); #1;
    chk("pre_rst_out", out1, 32'h12345678);
    chk("pre_rst_vld", vld1, 1);
    @(negedge Clk);
    v1 = 4'b0000; ordy1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out", out1, 0);
    chk("arst_vld", vld1, 0);
    chk("arst_src", src1, 0);
    #1 rst_n = 1'b1;
    d1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    v1 = 4'b1010; ordy1 = 1'b1;
    #1 chk("post_rst_rdy", r1, 4'b0010);
    @(posedge Clk); #1;
    chk("post_rst_src", src1, 1);
    chk("post_rst_vld", vld1, 1);
    chk("post_rst_out", out1, 32'hA1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
